// File: rtl/response_sequencer.sv
// Player-response sequencer for the memory game: matches synchronized key presses
// against the expected note, skips rests, times out idle players and tracks lives.
module response_sequencer #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int LIVES          = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] level_length,
    input  logic [3:0] expected_note,
    input  logic [3:0] note_inputs,
    output logic       advance,
    output logic       busy,
    output logic       mistake,
    output logic       done_win,
    output logic       done_lose,
    output logic [1:0] lives_left,
    output logic [3:0] notes_left
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    LIVES_INIT   = 2'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_PRESS,
        S_WAIT_RELEASE,
        S_ADVANCE,
        S_WIN,
        S_LOSE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    prev_q, prev_d;
    logic [CW-1:0] counter_q, counter_d;
    logic          correct_q, correct_d;
    logic [1:0]    lives_left_q, lives_left_d;
    logic [3:0]    notes_left_q, notes_left_d;
    logic          advance_q, advance_d;
    logic          busy_q, busy_d;
    logic          mistake_q, mistake_d;
    logic          done_win_q, done_win_d;
    logic          done_lose_q, done_lose_d;

    logic          press_seen;
    logic          press_ok;
    logic          timeout_hit;
    logic [1:0]    lives_dec;
    logic [3:0]    notes_dec;

    // A press is the rising edge of "any key down" after synchronization, so a
    // held key can never be recognised a second time.
    always_comb begin
        sync1_d     = note_inputs;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        press_seen  = (sync2_q != 4'b0000) && (prev_q == 4'b0000);
        press_ok    = press_seen && (sync2_q == expected_note);
        timeout_hit = (counter_q == TIMEOUT_LAST);
        lives_dec   = (lives_left_q != 2'd0) ? lives_left_q - 2'd1 : 2'd0;
        notes_dec   = (notes_left_q != 4'd0) ? notes_left_q - 4'd1 : 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sync1_q      <= 4'b0000;
            sync2_q      <= 4'b0000;
            prev_q       <= 4'b0000;
            counter_q    <= '0;
            correct_q    <= 1'b0;
            lives_left_q <= LIVES_INIT;
            notes_left_q <= 4'd0;
            advance_q    <= 1'b0;
            busy_q       <= 1'b0;
            mistake_q    <= 1'b0;
            done_win_q   <= 1'b0;
            done_lose_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            counter_q    <= counter_d;
            correct_q    <= correct_d;
            lives_left_q <= lives_left_d;
            notes_left_q <= notes_left_d;
            advance_q    <= advance_d;
            busy_q       <= busy_d;
            mistake_q    <= mistake_d;
            done_win_q   <= done_win_d;
            done_lose_q  <= done_lose_d;
        end
    end

    // notes_left drops on entry to ADVANCE so it changes together with the pulse;
    // ADVANCE then only has to test for zero.
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        correct_d    = correct_q;
        lives_left_d = lives_left_q;
        notes_left_d = notes_left_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    notes_left_d = level_length;
                    lives_left_d = LIVES_INIT;
                    correct_d    = 1'b0;
                    state_d      = (level_length == 4'd0) ? S_WIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (expected_note == 4'b0000) begin
                    notes_left_d = notes_dec;
                    state_d      = S_ADVANCE;
                end else begin
                    counter_d = '0;
                    state_d   = S_WAIT_PRESS;
                end
            end
            S_WAIT_PRESS: begin
                if (press_ok) begin
                    correct_d = 1'b1;
                    state_d   = S_WAIT_RELEASE;
                end else if (press_seen || timeout_hit) begin
                    correct_d    = 1'b0;
                    lives_left_d = lives_dec;
                    state_d      = (lives_dec == 2'd0) ? S_LOSE : S_WAIT_RELEASE;
                end else begin
                    counter_d = counter_q + CW'(1);
                end
            end
            S_WAIT_RELEASE: begin
                if (sync2_q == 4'b0000) begin
                    if (correct_q) begin
                        notes_left_d = notes_dec;
                        state_d      = S_ADVANCE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_ADVANCE: begin
                state_d = (notes_left_q == 4'd0) ? S_WIN : S_FETCH;
            end
            S_WIN:   state_d = S_IDLE;
            S_LOSE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered with it.
    always_comb begin
        advance_d   = (state_d == S_ADVANCE);
        busy_d      = state_d inside {S_FETCH, S_WAIT_PRESS, S_WAIT_RELEASE, S_ADVANCE};
        done_win_d  = (state_d == S_WIN);
        done_lose_d = (state_d == S_LOSE);
        mistake_d   = (state_q == S_WAIT_PRESS) &&
                      ((state_d == S_LOSE) || ((state_d == S_WAIT_RELEASE) && !correct_d));
    end

    assign advance    = advance_q;
    assign busy       = busy_q;
    assign mistake    = mistake_q;
    assign done_win   = done_win_q;
    assign done_lose  = done_lose_q;
    assign lives_left = lives_left_q;
    assign notes_left = notes_left_q;

endmodule

// File: tb/tb_response_sequencer.sv
// Bench for response_sequencer: a slot-level game model predicts every output pulse,
// and a monitor compares each pulse cycle against the predicted queue.
module tb_response_sequencer;

    localparam int TO = 16;
    localparam int LV = 3;

    typedef struct packed {
        logic       adv;
        logic       mis;
        logic       win;
        logic       lose;
        logic       bsy;
        logic [1:0] lives;
        logic [3:0] notes;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] level_length;
    logic [3:0] expected_note;
    logic [3:0] note_inputs;
    logic       advance, busy, mistake, done_win, done_lose;
    logic [1:0] lives_left;
    logic [3:0] notes_left;

    logic [3:0] slot_mem [16];
    int         sh_idx = 0;
    int         cur_len = 0;
    logic       load_round = 1'b0;

    exp_t       exp_q [$];
    exp_t       mon_got, mon_want;
    int         checks = 0;
    int         passes = 0;

    int         m_idx, m_lives, m_notes, m_len;
    bit         m_over;
    int         next_gap;
    bit         force_stray = 1'b0;

    always #5 clk = ~clk;

    response_sequencer #(.TIMEOUT_CYCLES(TO), .LIVES(LV)) dut (
        .clk(clk), .reset(reset), .start(start), .level_length(level_length),
        .expected_note(expected_note), .note_inputs(note_inputs),
        .advance(advance), .busy(busy), .mistake(mistake), .done_win(done_win),
        .done_lose(done_lose), .lives_left(lives_left), .notes_left(notes_left)
    );

    // External note shifter: steps one slot on the edge after each advance pulse.
    always @(posedge clk) begin
        if (load_round) sh_idx <= 0;
        else if (advance) sh_idx <= sh_idx + 1;
    end
    assign expected_note = (sh_idx < cur_len) ? slot_mem[sh_idx] : 4'b0000;

    always @(negedge clk) begin
        if (!reset && (advance || mistake || done_win || done_lose)) begin
            mon_got = {advance, mistake, done_win, done_lose, busy, lives_left, notes_left};
            checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL unexpected_pulse got=%b required=no pulse", mon_got);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got === mon_want) passes++;
                else $display("[TB] FAIL pulse got=%b required=%b (adv,mis,win,lose,busy,lives,notes)",
                              mon_got, mon_want);
            end
        end
    end

    task automatic checkOutput(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("[TB] FAIL %s got=%0d required=%0d", name, got, want);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input bit adv, input bit mis, input bit win, input bit lose, input bit bsy);
        exp_q.push_back({adv, mis, win, lose, bsy, 2'(m_lives), 4'(m_notes)});
    endtask

    task automatic modelConsume();
        m_idx++;
        m_notes--;
        pushExp(1, 0, 0, 0, 1);
        if (m_notes == 0) begin
            pushExp(0, 0, 1, 0, 0);
            m_over = 1;
        end
    endtask

    task automatic modelSkipRests();
        while (!m_over && m_idx < m_len && slot_mem[m_idx] == 4'b0000) modelConsume();
    endtask

    task automatic modelMistake();
        m_lives--;
        if (m_lives == 0) begin
            pushExp(0, 1, 0, 1, 0);
            m_over = 1;
        end else begin
            pushExp(0, 1, 0, 0, 1);
        end
    endtask

    task automatic beginRound(input int len);
        m_len   = len;
        cur_len = len;
        m_idx   = 0;
        m_lives = LV;
        m_notes = len;
        m_over  = 0;
        load_round = 1'b1;
        waitCycles(1);
        load_round   = 1'b0;
        level_length = 4'(len);
        start        = 1'b1;
        if (len == 0) begin
            pushExp(0, 0, 1, 0, 0);
            m_over = 1;
        end else begin
            modelSkipRests();
        end
        waitCycles(1);
        start        = 1'b0;
        level_length = 4'($urandom);
        next_gap     = 9;
    endtask

    // kind 0 presses 'key' for 'hold' cycles; kind 1 lets the note time out.
    task automatic applyStimulus(input int kind, input logic [3:0] key, input int hold);
        bit seen;
        waitCycles(next_gap - 1);
        if (force_stray || $urandom_range(0, 3) == 0) begin
            start        = 1'b1;
            level_length = 4'($urandom);
        end
        waitCycles(1);
        start = 1'b0;
        if (kind == 0) begin
            note_inputs = key;
            if (key == slot_mem[m_idx]) begin
                modelConsume();
                modelSkipRests();
            end else begin
                modelMistake();
            end
            waitCycles(hold);
            note_inputs = 4'b0000;
            next_gap    = 10;
        end else begin
            modelMistake();
            seen = 0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk);
                if (mistake) seen = 1;
            end
            checkOutput("timeout_fired", int'(seen), 1);
            @(posedge clk);
            #1;
            next_gap = 2;
        end
    endtask

    task automatic endRound(input string name);
        waitCycles(8);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) waitCycles(1);
        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL %s_missing_pulses got=%0d outstanding required=0", name, exp_q.size());
            exp_q.delete();
        end
        checkOutput({name, "_busy"}, int'(busy), 0);
        checkOutput({name, "_lives"}, int'(lives_left), m_lives);
        checkOutput({name, "_notes"}, int'(notes_left), m_notes);
    endtask

    task automatic setSlots(input logic [3:0] s0, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [3:0] s3);
        slot_mem[0] = s0;
        slot_mem[1] = s1;
        slot_mem[2] = s2;
        slot_mem[3] = s3;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog got=timeout required=completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int len, run, r;
        logic [3:0] key;
        int first;

        for (int i = 0; i < 16; i++) slot_mem[i] = 4'b0000;
        reset        = 1'b1;
        start        = 1'b0;
        level_length = 4'd0;
        note_inputs  = 4'b0000;
        waitCycles(2);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_advance", int'(advance), 0);
        checkOutput("rst_mistake", int'(mistake), 0);
        checkOutput("rst_done_win", int'(done_win), 0);
        checkOutput("rst_done_lose", int'(done_lose), 0);
        checkOutput("rst_lives", int'(lives_left), LV);
        checkOutput("rst_notes", int'(notes_left), 0);
        reset = 1'b0;
        waitCycles(2);

        // Clean win with rests between notes.
        setSlots(4'b0001, 4'b0000, 4'b0010, 4'b0000);
        beginRound(4);
        applyStimulus(0, 4'b0001, 4);
        applyStimulus(0, 4'b0010, 4);
        endRound("win_clean");

        // Wrong press, retry, plus a start request while busy.
        setSlots(4'b0001, 4'b0010, 4'b0000, 4'b0000);
        beginRound(2);
        applyStimulus(0, 4'b0100, 4);
        force_stray = 1'b1;
        applyStimulus(0, 4'b0001, 4);
        force_stray = 1'b0;
        applyStimulus(0, 4'b0010, 4);
        endRound("retry");

        setSlots(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        beginRound(2);
        applyStimulus(0, 4'b0100, 4);
        applyStimulus(0, 4'b0010, 4);
        applyStimulus(0, 4'b0011, 4);
        endRound("lose");

        // Timeout lands exactly TO cycles after WAIT_PRESS is entered.
        setSlots(4'b0001, 4'b0010, 4'b0000, 4'b0000);
        beginRound(2);
        modelMistake();
        first = -1;
        for (int n = 2; n <= 24; n++) begin
            waitCycles(1);
            if (mistake === 1'b1 && first < 0) first = n;
        end
        checkOutput("timeout_latency", first, 2 + TO);
        checkOutput("timeout_lives", int'(lives_left), LV - 1);
        next_gap = 2;
        applyStimulus(0, 4'b0001, 4);
        applyStimulus(0, 4'b0010, 4);
        endRound("timeout");

        // A key held well past the timeout is counted once.
        setSlots(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        beginRound(2);
        applyStimulus(0, 4'b0001, 40);
        applyStimulus(0, 4'b0001, 4);
        endRound("held_key");

        // Press recognised on the timeout cycle wins over the timeout.
        setSlots(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        beginRound(1);
        next_gap = 14;
        applyStimulus(0, 4'b0001, 4);
        endRound("press_on_timeout");

        // One cycle later the timeout comes first and the late press is ignored.
        beginRound(1);
        waitCycles(15);
        note_inputs = 4'b0001;
        modelMistake();
        waitCycles(4);
        note_inputs = 4'b0000;
        next_gap    = 10;
        applyStimulus(0, 4'b0001, 4);
        endRound("press_after_timeout");

        beginRound(0);
        checkOutput("len0_done_win_cycle2", int'(done_win), 1);
        endRound("len0");

        // Asynchronous reset in the middle of WAIT_PRESS.
        setSlots(4'b0001, 4'b0010, 4'b0000, 4'b0000);
        beginRound(2);
        applyStimulus(0, 4'b0100, 4);
        waitCycles(5);
        reset = 1'b1;
        #1;
        exp_q.delete();
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_lives", int'(lives_left), LV);
        checkOutput("midreset_notes", int'(notes_left), 0);
        waitCycles(2);
        reset = 1'b0;
        waitCycles(2);

        for (int rnd = 0; rnd < 14; rnd++) begin
            len = $urandom_range(1, 12);
            run = 0;
            for (int i = 0; i < len; i++) begin
                if (run < 3 && $urandom_range(0, 3) == 0) begin
                    slot_mem[i] = 4'b0000;
                    run++;
                end else begin
                    slot_mem[i] = 4'b0001 << $urandom_range(0, 3);
                    run = 0;
                end
            end
            beginRound(len);
            while (!m_over) begin
                r = $urandom_range(0, 99);
                if (r < 60) begin
                    applyStimulus(0, slot_mem[m_idx], $urandom_range(3, 30));
                end else if (r < 85) begin
                    do key = 4'($urandom_range(1, 15)); while (key == slot_mem[m_idx]);
                    applyStimulus(0, key, $urandom_range(3, 30));
                end else begin
                    applyStimulus(1, 4'b0000, 0);
                end
            end
            endRound("random");
            waitCycles($urandom_range(2, 6));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
